multiplexed_display_controller: RTL and testbench
=================================================

MULTIPLEXED_DISPLAY_CONTROLLER -- requirements
Module: multiplexed_display_controller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter CLK_DIVIDER, default 100000: clk cycles per digit slot, legal range >= 4.
REQ-003 SHALL have parameter BRIGHTNESS_WIDTH, default 4: width of the brightness PWM control.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 means segment outputs are active-low.
REQ-005 SHALL have parameter DIGIT_ACTIVE_LOW, default 1: 1 means digit enables are active-low.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port load, input, 1: single-cycle strobe that captures digit_values and dp_mask.
REQ-009 SHALL have port digit_values, input, 4*NUM_DIGITS: hex nibbles; nibble 0 (bits 3:0) is the least significant digit.
REQ-010 SHALL have port dp_mask, input, NUM_DIGITS: per-digit decimal point, 1 = lit.
REQ-011 SHALL have port blank_leading_zeros, input, 1: enables leading-zero suppression.
REQ-012 SHALL have port brightness, input, BRIGHTNESS_WIDTH: PWM duty code.
REQ-013 SHALL have port segments, output, 8: order {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
REQ-014 SHALL have port digit_enable, output, NUM_DIGITS: one-hot digit select, polarity per DIGIT_ACTIVE_LOW.
REQ-015 SHALL have port slot_tick, output, 1: one-cycle pulse at the last cycle of every slot.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse at the last cycle of the last slot.

Function
REQ-017 SHALL count a prescaler 0..CLK_DIVIDER-1, wrapping to 0; slot_tick SHALL be 1 exactly when prescaler == CLK_DIVIDER-1.
REQ-018 SHALL advance the digit index by 1 on each slot_tick, wrapping from NUM_DIGITS-1 to 0; frame_done = slot_tick AND index == NUM_DIGITS-1.
REQ-019 SHALL double-buffer the data: load writes the shadow register; shadow copies to the active register on frame_done only, so a frame never mixes old and new data.
REQ-020 SHALL, when load and frame_done coincide, write the new inputs into both shadow and active in that cycle.
REQ-021 SHALL, on multiple loads within one frame, display the last load at the next frame boundary.
REQ-022 SHALL decode the active nibble as full hex 0-F (A,b,C,d,E,F glyphs).
REQ-023 SHALL, when blank_leading_zeros=1, blank digit i (i>0) if nibbles i..NUM_DIGITS-1 are all 0; digit 0 SHALL never be blanked; a blanked digit still shows its dp when its dp_mask bit is 1.
REQ-024 SHALL run a free BRIGHTNESS_WIDTH-bit PWM counter incrementing every clk; the selected digit is enabled only while pwm_count < brightness. brightness=0 SHALL keep all digits dark.
REQ-025 SHALL sample brightness on slot_tick; a change SHALL take effect from the next slot.
REQ-026 SHALL force all digit enables inactive during prescaler == 0 of every slot (anti-ghosting blank cycle).
REQ-027 SHALL register segments and digit_enable: one clk latency from index/prescaler state to outputs.
REQ-028 SHALL keep segments and digit_enable mutually consistent: the enabled digit always shows its own data.

Reset
REQ-029 SHALL, on reset_n low, immediately clear prescaler, index, PWM counter, shadow and active registers, and sampled brightness to 0.
REQ-030 SHALL, while in reset, drive segments and digit_enable to their inactive levels and slot_tick/frame_done to 0.
REQ-031 SHALL, after reset release, resume from index 0, prescaler 0, with display blank until the first load reaches the active register.
REQ-032 SHALL discard a load asserted while reset_n is low.

Verification (NUM_DIGITS=4, CLK_DIVIDER=8, BRIGHTNESS_WIDTH=2, active-low)
REQ-033 SHALL cover: reset then 40 clks -> slot_tick every 8 clks, frame_done every 32, digit_enable cycles 1110,1101,1011,0111 (LSB = digit 0).
REQ-034 SHALL cover: load 16'h1234 mid-frame, brightness=3 -> old data until frame_done, then digit 0 segments = ~8'h4C ("4"), digit 3 = ~8'h06 ("1").
REQ-035 SHALL cover: load 16'h0070, blank_leading_zeros=1, dp_mask=4'b1000 -> digits 3 and 2 segments off except digit 3 dp lit; digits 1 and 0 show 7 and 0.
REQ-036 SHALL cover: brightness=1 -> selected digit enabled 1 clk of each 4-clk PWM period; brightness=0 -> digit_enable = 4'b1111 throughout.
REQ-037 SHALL cover: load coinciding with frame_done -> new value visible in the immediately following slot.
REQ-038 SHALL cover: reset_n pulsed low mid-slot -> outputs inactive in the same cycle, active register 0, index restarts at 0.

Source files
------------

// File: rtl/multiplexed_display_controller.sv
// Multiplexed 7-segment display controller.
//   Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus.
//   A prescaler splits time into slots of CLK_DIVIDER clocks. Each slot
//   drives one digit. Display data is double-buffered, so a frame never
//   mixes old and new values. A free-running PWM counter dims the display.
// Ports:
//   clk, reset_n         - clock; asynchronous active-low reset
//   load                 - strobe; captures digit_values/dp_mask into shadow
//   digit_values         - NUM_DIGITS hex nibbles, nibble 0 = rightmost digit
//   dp_mask              - per-digit decimal point, 1 = lit
//   blank_leading_zeros  - suppress leading zero digits (digit 0 never blanked)
//   brightness           - PWM duty code, sampled once per slot
//   segments             - {dp,g,f,e,d,c,b,a}, registered
//   digit_enable         - one-hot digit select, registered
//   slot_tick            - last cycle of every slot
//   frame_done           - last cycle of the last slot
module multiplexed_display_controller #(
  parameter int NUM_DIGITS       = 4,
  parameter int CLK_DIVIDER      = 100000,
  parameter int BRIGHTNESS_WIDTH = 4,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digit_values,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic                          blank_leading_zeros,
  input  logic [BRIGHTNESS_WIDTH-1:0]   brightness,
  output logic [7:0]                    segments,
  output logic [NUM_DIGITS-1:0]         digit_enable,
  output logic                          slot_tick,
  output logic                          frame_done
);

  localparam int PW = $clog2(CLK_DIVIDER);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PS_LAST  = PW'(CLK_DIVIDER - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  // Output XOR masks; they are also the inactive (off) levels.
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]                   prescaler;
  logic [IW-1:0]                   index;
  logic [BRIGHTNESS_WIDTH-1:0]     pwm_count;
  logic [BRIGHTNESS_WIDTH-1:0]     bright_q;
  logic [NUM_DIGITS-1:0][3:0]      shadow_val;
  logic [NUM_DIGITS-1:0][3:0]      active_val;
  logic [NUM_DIGITS-1:0]           shadow_dp;
  logic [NUM_DIGITS-1:0]           active_dp;
  // Display stays blank until a real load has reached the active buffer.
  logic                            shadow_ok;
  logic                            active_ok;

  assign slot_tick  = (prescaler == PS_LAST);
  assign frame_done = slot_tick && (index == IDX_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler  <= '0;
      index      <= '0;
      pwm_count  <= '0;
      bright_q   <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      shadow_ok  <= 1'b0;
      active_val <= '0;
      active_dp  <= '0;
      active_ok  <= 1'b0;
    end else begin
      prescaler <= slot_tick ? '0 : prescaler + 1'b1;
      pwm_count <= pwm_count + 1'b1;
      if (slot_tick) begin
        index    <= (index == IDX_LAST) ? '0 : index + 1'b1;
        bright_q <= brightness;
      end
      if (load) begin
        shadow_val <= digit_values;
        shadow_dp  <= dp_mask;
        shadow_ok  <= 1'b1;
      end
      // A load landing on the frame boundary bypasses the shadow so it
      // shows in the very next slot instead of a frame later.
      if (frame_done) begin
        if (load) begin
          active_val <= digit_values;
          active_dp  <= dp_mask;
          active_ok  <= 1'b1;
        end else begin
          active_val <= shadow_val;
          active_dp  <= shadow_dp;
          active_ok  <= shadow_ok;
        end
      end
    end
  end

  // zero_from[i]: nibbles i..NUM_DIGITS-1 of the active buffer are all zero.
  logic [NUM_DIGITS-1:0] zero_from;
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (active_val[NUM_DIGITS-1] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      zero_from[i] = zero_from[i+1] & (active_val[i] == 4'h0);
  end

  logic [3:0] nib;
  logic [6:0] glyph;
  logic       blank_cur;
  logic [7:0] seg_on;
  logic [NUM_DIGITS-1:0] en_on;

  assign nib       = active_val[index];
  assign blank_cur = blank_leading_zeros && (index != '0) && zero_from[index];

  // Active-high {g,f,e,d,c,b,a}. The '4' glyph is this product's c,d,g form.
  always_comb begin
    glyph = 7'h00;
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h4C;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  end

  // Segments always follow the indexed digit, so whatever digit is enabled
  // shows its own data; enable alone carries the PWM and ghost blanking.
  always_comb begin
    seg_on = 8'h00;
    en_on  = '0;
    if (active_ok) seg_on = {active_dp[index], blank_cur ? 7'h00 : glyph};
    if (prescaler != '0 && pwm_count < bright_q) en_on[index] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      segments     <= SEG_OFF;
      digit_enable <= DIG_OFF;
    end else begin
      segments     <= seg_on ^ SEG_OFF;
      digit_enable <= en_on ^ DIG_OFF;
    end
  end

endmodule

// File: tb/tb_multiplexed_display_controller.sv
module tb_multiplexed_display_controller;
  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BW  = 2;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [15:0] digit_values;
  logic [3:0]  dp_mask;
  logic        blank_leading_zeros;
  logic [1:0]  brightness;
  logic [7:0]  segments;
  logic [3:0]  digit_enable;
  logic        slot_tick;
  logic        frame_done;

  multiplexed_display_controller #(
    .NUM_DIGITS(N), .CLK_DIVIDER(DIV), .BRIGHTNESS_WIDTH(BW),
    .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .digit_values(digit_values),
    .dp_mask(dp_mask), .blank_leading_zeros(blank_leading_zeros),
    .brightness(brightness), .segments(segments), .digit_enable(digit_enable),
    .slot_tick(slot_tick), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] en;
    logic       tick;
    logic       fd;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: time since reset plus the two data buffers.
  int          t;
  logic [15:0] sh_val, ac_val;
  logic [3:0]  sh_dp, ac_dp;
  bit          sh_ok, ac_ok;
  int          bq;
  logic [7:0]  pend_seg;
  logic [3:0]  pend_en;
  logic        cur_blz;
  logic [1:0]  cur_br;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h4C, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[n];
  endfunction

  // One clock: drive inputs at the falling edge, push the outputs expected
  // during this cycle, then advance the model across the next rising edge.
  task automatic cyc(input logic rn, input logic ld, input logic [15:0] dv,
                     input logic [3:0] dpm, input logic blz, input logic [1:0] br);
    int idx, ps, pwm;
    logic [7:0] s;
    logic tk, fd;
    obs_t e;
    @(negedge clk);
    reset_n = rn; load = ld; digit_values = dv; dp_mask = dpm;
    blank_leading_zeros = blz; brightness = br;
    if (!rn) begin
      t = 0; sh_val = '0; ac_val = '0; sh_dp = '0; ac_dp = '0;
      sh_ok = 0; ac_ok = 0; bq = 0;
      pend_seg = 8'hFF; pend_en = 4'hF;
      e = {8'hFF, 4'hF, 1'b0, 1'b0};
      exp_q.push_back(e);
      return;
    end
    tk = (t % DIV) == DIV - 1;
    fd = tk && ((t / DIV) % N) == N - 1;
    e = {pend_seg, pend_en, tk, fd};
    exp_q.push_back(e);
    idx = (t / DIV) % N;
    ps  = t % DIV;
    pwm = t % (1 << BW);
    s = 8'h00;
    if (ac_ok) begin
      if (!(blz && idx > 0 && (ac_val >> (4 * idx)) == 16'h0))
        s[6:0] = glyph(ac_val[4*idx +: 4]);
      s[7] = ac_dp[idx];
    end
    pend_seg = ~s;
    pend_en  = (ps != 0 && pwm < bq) ? ~(4'b0001 << idx) : 4'hF;
    if (fd) begin
      if (ld) begin ac_val = dv; ac_dp = dpm; ac_ok = 1; end
      else begin ac_val = sh_val; ac_dp = sh_dp; ac_ok = sh_ok; end
    end
    if (ld) begin sh_val = dv; sh_dp = dpm; sh_ok = 1; end
    if (tk) bq = br;
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b0, 16'($urandom), 4'($urandom), cur_blz, cur_br);
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) run(1);
  endtask

  task automatic ld(input logic [15:0] dv, input logic [3:0] dpm);
    cyc(1'b1, 1'b1, dv, dpm, cur_blz, cur_br);
  endtask

  // Monitor: compares every cycle that has an expectation queued.
  obs_t mon_e, mon_a;
  initial forever begin
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {segments, digit_enable, slot_tick, frame_done};
      vectors++;
      if (mon_a !== mon_e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got seg=%h en=%b tick=%b fd=%b, want seg=%h en=%b tick=%b fd=%b",
                 $time, mon_a.seg, mon_a.en, mon_a.tick, mon_a.fd,
                 mon_e.seg, mon_e.en, mon_e.tick, mon_e.fd);
      end
    end
  end

  initial begin
    logic [15:0] rv;
    reset_n = 1'b0; load = 1'b0; digit_values = '0; dp_mask = '0;
    blank_leading_zeros = 1'b0; brightness = '0;
    cur_blz = 1'b0; cur_br = 2'd3;
    // Loads during reset must be discarded.
    repeat (3) cyc(1'b0, 1'b1, 16'hFFFF, 4'hF, 1'b0, 2'd3);
    run(40);
    // Mid-frame load: old (blank) data until the frame boundary.
    run_to(12); ld(16'h1234, 4'b0000); run(70);
    // Leading-zero suppression with dp on a blanked digit.
    cur_blz = 1'b1;
    run_to(5); ld(16'h0070, 4'b1000); run(70);
    // Dimming and fully dark.
    cur_br = 2'd1; run(70);
    cur_br = 2'd0; run(40);
    cur_br = 2'd3;
    // Load exactly on frame_done.
    run_to(FRAME - 1); ld(16'hABCD, 4'b0101); run(20);
    // Reset pulse in the middle of a slot.
    run_to(19);
    cyc(1'b0, 1'b1, 16'h5555, 4'hF, cur_blz, cur_br);
    cyc(1'b0, 1'b1, 16'h6666, 4'hF, cur_blz, cur_br);
    run(40);
    // Randomized traffic, including several loads per frame.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 63) == 0) cur_blz = 1'($urandom);
      if ($urandom_range(0, 47) == 0) cur_br  = 2'($urandom);
      rv = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
      cyc(1'b1, 1'($urandom_range(0, 15) == 0), rv, 4'($urandom), cur_blz, cur_br);
    end
    run_to(FRAME - 1); ld(16'h0F09, 4'b0010); run(40);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
